// File: rtl/cpu_trace_buffer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : cpu_trace_buffer_if
// Description : Bundle of the CPU sample buses, the pop handshake and the
//               trace-buffer status outputs.
//               master : drives addr/result/capture_en/rd_en, observes status
//               slave  : the trace buffer itself
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface cpu_trace_buffer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [31:0]         addr;         // CPU instruction address
    logic [31:0]         result;       // CPU result bus
    logic                capture_en;   // sampling enable
    logic                rd_en;        // pop request for the head entry
    logic [31:0]         rd_addr;      // head entry addr, 0 when empty
    logic [31:0]         rd_result;    // head entry result, 0 when empty
    logic                empty;        // no entries held
    logic                full;         // 2**DEPTH_LOG2 entries held
    logic [DEPTH_LOG2:0] count;        // occupancy
    logic                overflow;     // sticky, a capture was dropped
    logic                halted;       // PC stall detected
    logic [31:0]         instr_count;  // captures attempted, wraps

    modport master (
        output addr, result, capture_en, rd_en,
        input  rd_addr, rd_result, empty, full, count, overflow, halted,
               instr_count
    );

    modport slave (
        input  addr, result, capture_en, rd_en,
        output rd_addr, rd_result, empty, full, count, overflow, halted,
               instr_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : cpu_trace_buffer
// Description : Captures one (addr, result) pair per retired instruction of
//               the single-cycle CPU into a show-ahead FIFO, flags a PC stall
//               as "halted" and counts retired instructions.
//               clk : sole clock, rising edge
//               rst : asynchronous active-high reset
//               bus : cpu_trace_buffer_if.slave (sample buses, pop, status)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module cpu_trace_buffer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int HALT_CYCLES = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    cpu_trace_buffer_if.slave    bus
);

    localparam int                  c_depth       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count  = c_depth[DEPTH_LOG2:0];
    localparam logic [7:0]          c_halt_cycles = HALT_CYCLES[7:0];
    localparam logic [7:0]          c_stall_max   = 8'hFF;

    // Each entry packs {addr, result}
    logic [63:0]           r_mem [0:c_depth-1];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_first;
    logic [31:0]           r_last_addr;
    logic [7:0]            r_stall_cnt;
    logic                  r_overflow;
    logic                  r_halted;
    logic [31:0]           r_instr_count;

    logic                  w_capture;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_empty;
    logic                  w_full;
    logic [7:0]            w_stall_next;
    logic [63:0]           w_head;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);
    // The very first sample after reset captures regardless of last_addr
    assign w_capture = bus.capture_en && (r_first || (bus.addr != r_last_addr));
    assign w_pop     = bus.rd_en && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    // Halt counter: anything that is enabled, past the first sample and not a
    // capture must be a repeat of last_addr
    always_comb begin
        w_stall_next = r_stall_cnt;
        if (w_capture) begin
            w_stall_next = 8'd0;
        end else if (bus.capture_en && !r_first && (r_stall_cnt != c_stall_max)) begin
            w_stall_next = r_stall_cnt + 8'd1;
        end
    end

    // Storage needs no reset: entries are only visible through count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.addr, bus.result};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_first       <= 1'b1;
            r_last_addr   <= '0;
            r_stall_cnt   <= 8'd0;
            r_overflow    <= 1'b0;
            r_halted      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_capture) begin
                r_first       <= 1'b0;
                r_last_addr   <= bus.addr;
                r_instr_count <= r_instr_count + 32'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_stall_cnt <= w_stall_next;
            // Registered from the next stall value so halted rises on the
            // same edge the threshold is reached and drops on the capture edge
            r_halted    <= (w_stall_next >= c_halt_cycles);
        end
    end

    assign w_head          = r_mem[r_rptr];
    assign bus.rd_addr     = w_empty ? 32'd0 : w_head[63:32];
    assign bus.rd_result   = w_empty ? 32'd0 : w_head[31:0];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.halted      = r_halted;
    assign bus.instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_cpu_trace_buffer
// Description : Directed, table-driven bench for cpu_trace_buffer with hand
//               sequences for fill/overflow, full push+pop, halt detection and
//               asynchronous reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cpu_trace_buffer;

    localparam int c_depth_log2 = 4;

    typedef struct {
        logic        do_rst;
        logic [31:0] addr;
        logic [31:0] result;
        logic        cap;
        logic        rd;
        logic [4:0]  e_count;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
        logic        e_halt;
        logic [31:0] e_instr;
        logic [31:0] e_raddr;
        logic [31:0] e_rres;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    cpu_trace_buffer_if #(.DEPTH_LOG2(c_depth_log2)) bus ();

    cpu_trace_buffer #(
        .DEPTH_LOG2  (c_depth_log2),
        .HALT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [4:0] cnt, input logic emp,
                             input logic ful, input logic ovf, input logic hlt,
                             input logic [31:0] instr, input logic [31:0] raddr,
                             input logic [31:0] rres);
        chk({tag, " count"},       32'(bus.count),    32'(cnt));
        chk({tag, " empty"},       32'(bus.empty),    32'(emp));
        chk({tag, " full"},        32'(bus.full),     32'(ful));
        chk({tag, " overflow"},    32'(bus.overflow), 32'(ovf));
        chk({tag, " halted"},      32'(bus.halted),   32'(hlt));
        chk({tag, " instr_count"}, bus.instr_count,   instr);
        chk({tag, " rd_addr"},     bus.rd_addr,       raddr);
        chk({tag, " rd_result"},   bus.rd_result,     rres);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic cycle(input logic [31:0] a, input logic [31:0] r, input logic cap,
                         input logic rd);
        bus.addr       = a;
        bus.result     = r;
        bus.capture_en = cap;
        bus.rd_en      = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.capture_en = 1'b0;
        bus.rd_en      = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] a, input logic [31:0] res,
                                input logic cap, input logic rd, input logic [4:0] cnt,
                                input logic emp, input logic ful, input logic ovf,
                                input logic hlt, input logic [31:0] instr,
                                input logic [31:0] raddr, input logic [31:0] rres);
        vec_t v;
        v.do_rst = r;   v.addr = a;     v.result = res;  v.cap = cap;    v.rd = rd;
        v.e_count = cnt; v.e_empty = emp; v.e_full = ful; v.e_ovf = ovf; v.e_halt = hlt;
        v.e_instr = instr; v.e_raddr = raddr; v.e_rres = rres;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        clk            = 1'b0;
        rst            = 1'b1;
        bus.addr       = '0;
        bus.result     = '0;
        bus.capture_en = 1'b0;
        bus.rd_en      = 1'b0;

        //              rst addr   result cap rd cnt emp ful ovf hlt instr rd_addr rd_res
        vecs[0]  = mk(1, 0,     0,     0, 0, 0,  1,  0,  0,  0,  0,  0,     0);
        vecs[1]  = mk(0, 32'h0, 32'h10, 1, 0, 1,  0,  0,  0,  0,  1,  32'h0, 32'h10);
        vecs[2]  = mk(0, 32'h4, 32'h20, 1, 0, 2,  0,  0,  0,  0,  2,  32'h0, 32'h10);
        vecs[3]  = mk(0, 32'h8, 32'h30, 1, 0, 3,  0,  0,  0,  0,  3,  32'h0, 32'h10);
        vecs[4]  = mk(0, 32'hC, 32'h40, 1, 0, 4,  0,  0,  0,  0,  4,  32'h0, 32'h10);
        vecs[5]  = mk(0, 32'hC, 32'h0,  0, 1, 3,  0,  0,  0,  0,  4,  32'h4, 32'h20);
        vecs[6]  = mk(0, 32'hC, 32'h0,  0, 1, 2,  0,  0,  0,  0,  4,  32'h8, 32'h30);
        vecs[7]  = mk(0, 32'hC, 32'h0,  0, 1, 1,  0,  0,  0,  0,  4,  32'hC, 32'h40);
        vecs[8]  = mk(0, 32'hC, 32'h0,  0, 1, 0,  1,  0,  0,  0,  4,  32'h0, 32'h0);
        vecs[9]  = mk(0, 32'hC, 32'h0,  0, 1, 0,  1,  0,  0,  0,  4,  32'h0, 32'h0);
        vecs[10] = mk(1, 0,     0,      0, 0, 0,  1,  0,  0,  0,  0,  0,     0);
        vecs[11] = mk(0, 32'h8, 32'h81, 1, 0, 1,  0,  0,  0,  0,  1,  32'h8, 32'h81);
        vecs[12] = mk(0, 32'h8, 32'h90, 1, 0, 1,  0,  0,  0,  0,  1,  32'h8, 32'h81);
        vecs[13] = mk(0, 32'h8, 32'h91, 1, 0, 1,  0,  0,  0,  0,  1,  32'h8, 32'h81);
        vecs[14] = mk(0, 32'hC, 32'h82, 1, 0, 2,  0,  0,  0,  0,  2,  32'h8, 32'h81);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_rst) do_reset();
            else cycle(vecs[i].addr, vecs[i].result, vecs[i].cap, vecs[i].rd);
            chk_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_empty,
                      vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_halt, vecs[i].e_instr,
                      vecs[i].e_raddr, vecs[i].e_rres);
        end

        // Fill to 16 then one dropped capture
        do_reset();
        for (int i = 0; i < 16; i++) cycle(32'h100 + 32'(4 * i), 32'(i), 1'b1, 1'b0);
        chk_state("fill16", 5'd16, 0, 1, 0, 0, 32'd16, 32'h100, 32'h0);
        cycle(32'h200, 32'hAA, 1'b1, 1'b0);
        chk_state("drop17", 5'd16, 0, 1, 1, 0, 32'd17, 32'h100, 32'h0);

        // Full with simultaneous pop: push lands, no overflow
        do_reset();
        for (int i = 0; i < 16; i++) cycle(32'h100 + 32'(4 * i), 32'(i), 1'b1, 1'b0);
        cycle(32'h200, 32'hBB, 1'b1, 1'b1);
        chk_state("fullpp", 5'd16, 0, 1, 0, 0, 32'd17, 32'h104, 32'h1);
        for (int i = 0; i < 15; i++) cycle(32'h200, 32'h0, 1'b0, 1'b1);
        chk_state("drain15", 5'd1, 0, 0, 0, 0, 32'd17, 32'h200, 32'hBB);

        // Halt detection with HALT_CYCLES = 8
        do_reset();
        cycle(32'h20, 32'h1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(32'h20, 32'h5, 1'b1, 1'b0);
        chk_state("stall7", 5'd1, 0, 0, 0, 0, 32'd1, 32'h20, 32'h1);
        cycle(32'h20, 32'h5, 1'b1, 1'b0);
        chk_state("stall8", 5'd1, 0, 0, 0, 1, 32'd1, 32'h20, 32'h1);
        cycle(32'h24, 32'h2, 1'b1, 1'b0);
        chk_state("resume", 5'd2, 0, 0, 0, 0, 32'd2, 32'h20, 32'h1);

        // Asynchronous reset between edges, then first-sample capture at addr 0
        do_reset();
        cycle(32'h10, 32'h1, 1'b1, 1'b0);
        cycle(32'h14, 32'h2, 1'b1, 1'b0);
        cycle(32'h18, 32'h3, 1'b1, 1'b0);
        cycle(32'h1C, 32'h4, 1'b1, 1'b0);
        cycle(32'h0,  32'h5, 1'b1, 1'b0);
        chk_state("load5", 5'd5, 0, 0, 0, 0, 32'd5, 32'h10, 32'h1);
        bus.capture_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 5'd0, 1, 0, 0, 0, 32'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cycle(32'h0, 32'h99, 1'b1, 1'b0);
        chk_state("post_rst", 5'd1, 0, 0, 0, 0, 32'd1, 32'h0, 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
